pe_wb_engine: RTL
=================

PE_WB_ENGINE -- requirements
Module: pe_wb_engine

Interface
REQ-001 SHALL have these parameters (name, default, meaning): W_SIZE 9, row/col width; W_CHANNEL 9, channel width; Tout 16, output lanes; W_PSUM 32, psum width; PE_LATENCY 4, cycles from run to pe_vld; FIFO_DEPTH 4, result-entry slots; ADDR_WIDTH = W_CHANNEL+2*W_SIZE.
REQ-002 SHALL have these ports (name, direction, width, meaning): clk in 1, clock; rstn in 1, asynchronous active-low reset.
REQ-003 c_ctrl_data_run in 1, a PE beat is issued this cycle.
REQ-004 c_row, c_col in W_SIZE each; c_chn_base in W_CHANNEL; c_first_chn in 1 (beat starts a new psum); c_end_frame in 1.
REQ-005 o_req_ifm, o_req_filter out 1, buffer-manager requests.
REQ-006 pe_vld in 1; pe_acc in Tout*W_PSUM, lane j at bits [j*W_PSUM +: W_PSUM].
REQ-007 psum_we out 1; psum_ready in 1; psum_addr out ADDR_WIDTH; psum_wdata out W_PSUM; psum_acc out 1 (buffer adds wdata to stored value).
REQ-008 o_busy, o_frame_done, o_err_ovf out 1.

Function
REQ-009 o_req_ifm and o_req_filter SHALL equal c_ctrl_data_run registered by one cycle.
REQ-010 A PE_LATENCY-deep shift register SHALL carry {row, col, chn_base, first_chn}, loaded every cycle, so tap PE_LATENCY-1 aligns with pe_vld.
REQ-011 When pe_vld=1 and the FIFO is not full, the FIFO SHALL store {all Tout lanes, aligned coordinates, first_chn}.
REQ-012 When pe_vld=1 and the FIFO is full, the entry SHALL be dropped and o_err_ovf SHALL set and stay set until reset.
REQ-013 Drain FSM states: IDLE, LOAD, WRITE.
REQ-014 IDLE->LOAD when FIFO not empty; LOAD pops head into a holding register, sets lane=0, ->WRITE.
REQ-015 In WRITE, psum_we=1 with lane data; the lane advances only on the cycle where psum_we && psum_ready.
REQ-016 While psum_ready=0, psum_we, psum_addr, psum_wdata, psum_acc SHALL hold unchanged.
REQ-017 After lane Tout-1 is accepted: ->LOAD if the FIFO is not empty, else ->IDLE.
REQ-018 A FIFO push and pop in the same cycle SHALL both take effect; full/empty counts are unchanged.
REQ-019 psum_addr = {chn_base+lane (modulo 2^W_CHANNEL), row, col}, MSB to LSB.
REQ-020 psum_wdata SHALL equal the lane value unmodified; no saturation.
REQ-021 psum_acc SHALL be the inverse of the stored first_chn.
REQ-022 psum outputs SHALL be registered; sustained throughput is one lane per cycle, so one entry costs Tout cycles.
REQ-023 o_busy=1 while any of: pipeline holds a run beat, FIFO not empty, FSM not IDLE.
REQ-024 c_end_frame SHALL set a pending flag; o_frame_done pulses one cycle on the first cycle the flag is set and o_busy=0, then the flag clears.
REQ-025 c_end_frame arriving while the flag is already set SHALL be absorbed (a single pulse).
REQ-026 pe_vld with no matching run beat SHALL still be written, using the coordinates present at the tap.

Reset
REQ-027 rstn low SHALL asynchronously clear: all outputs to 0, FSM to IDLE, FIFO pointers, shift register, pending flag, o_err_ovf.
REQ-028 Reset mid-WRITE SHALL drop remaining lanes; no write is issued after rstn releases until new pe_vld.

Structure
REQ-029 Defaults for W_SIZE, W_CHANNEL, Tout, W_PSUM, PE_LATENCY and the FSM state encoding SHALL live in the shared controller_params package.
REQ-030 The FIFO SHALL be one sub-module, pe_wb_fifo (parametrised width and depth, full/empty outputs); everything else stays inline.

Verification
REQ-031 Single run at row=3, col=5, chn_base=8, first_chn=1; pe_vld PE_LATENCY cycles later; psum_ready=1 -> 16 consecutive writes, addr={8..23,3,5}, psum_acc=0.
REQ-032 Same beat with first_chn=0 and psum_ready low for 3 cycles at lane 2 -> lane 2 is held 3 cycles, no lane is skipped or duplicated, psum_acc=1.
REQ-033 Five pe_vld back-to-back, psum_ready=0 -> 4 entries stored, o_err_ovf=1; after release exactly 64 writes.
REQ-034 chn_base=2^W_CHANNEL-4 -> lane 4 address channel field wraps to 0.
REQ-035 c_end_frame issued during a drain -> o_frame_done pulses once, one cycle after the last lane is accepted.
REQ-036 rstn asserted at lane 7 -> all outputs 0 immediately; no writes after release; o_busy=0.

Source files
------------

// File: rtl/controller_params.sv
// Shared defaults and FSM encoding for the PE write-back path and its controller.
package controller_params;
    localparam int DEF_W_SIZE     = 9;
    localparam int DEF_W_CHANNEL  = 9;
    localparam int DEF_TOUT       = 16;
    localparam int DEF_W_PSUM     = 32;
    localparam int DEF_PE_LATENCY = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_WRITE = 2'd2
    } wb_state_e;
endpackage

// File: rtl/pe_wb_engine_if.sv
// Psum-buffer write port: one lane per accepted beat, valid/ready style.
interface pe_wb_engine_if import controller_params::*; #(
    parameter int ADDR_WIDTH = DEF_W_CHANNEL + 2 * DEF_W_SIZE,
    parameter int W_PSUM     = DEF_W_PSUM
) ();
    logic                  psum_we;
    logic                  psum_ready;
    logic [ADDR_WIDTH-1:0] psum_addr;
    logic [W_PSUM-1:0]     psum_wdata;
    logic                  psum_acc;

    modport master (output psum_we, psum_addr, psum_wdata, psum_acc, input psum_ready);
    modport slave  (input psum_we, psum_addr, psum_wdata, psum_acc, output psum_ready);
endinterface

// File: rtl/pe_wb_fifo.sv
// Small result-entry FIFO with registered pointers and occupancy count.
module pe_wb_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push, do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end
endmodule

// File: rtl/pe_wb_engine.sv
// Captures PE result vectors with their coordinates and drains them lane by lane
// into the psum buffer, tracking busy / frame-done / overflow status.
module pe_wb_engine import controller_params::*; #(
    parameter int W_SIZE     = DEF_W_SIZE,
    parameter int W_CHANNEL  = DEF_W_CHANNEL,
    parameter int Tout       = DEF_TOUT,
    parameter int W_PSUM     = DEF_W_PSUM,
    parameter int PE_LATENCY = DEF_PE_LATENCY,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_WIDTH = W_CHANNEL + 2 * W_SIZE
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   c_ctrl_data_run,
    input  logic [W_SIZE-1:0]      c_row,
    input  logic [W_SIZE-1:0]      c_col,
    input  logic [W_CHANNEL-1:0]   c_chn_base,
    input  logic                   c_first_chn,
    input  logic                   c_end_frame,
    output logic                   o_req_ifm,
    output logic                   o_req_filter,
    input  logic                   pe_vld,
    input  logic [Tout*W_PSUM-1:0] pe_acc,
    pe_wb_engine_if.master         psum,
    output logic                   o_busy,
    output logic                   o_frame_done,
    output logic                   o_err_ovf
);
    localparam int LANE_W = (Tout > 1) ? $clog2(Tout) : 1;

    typedef struct packed {
        logic                 run;
        logic [W_SIZE-1:0]    row;
        logic [W_SIZE-1:0]    col;
        logic [W_CHANNEL-1:0] chn;
        logic                 first;
    } beat_t;

    typedef struct packed {
        logic [Tout*W_PSUM-1:0] acc;
        logic [W_SIZE-1:0]      row;
        logic [W_SIZE-1:0]      col;
        logic [W_CHANNEL-1:0]   chn;
        logic                   first;
    } entry_t;

    function automatic logic [ADDR_WIDTH-1:0] lane_addr(input entry_t e, input logic [LANE_W-1:0] l);
        return {e.chn + W_CHANNEL'(l), e.row, e.col};
    endfunction

    function automatic logic [W_PSUM-1:0] lane_data(input entry_t e, input logic [LANE_W-1:0] l);
        return e.acc[l*W_PSUM +: W_PSUM];
    endfunction

    logic        run_p0;
    beat_t       beat_p [PE_LATENCY];
    logic        pipe_busy;
    entry_t      entry_in, head, hold;
    logic        fifo_full, fifo_empty, push, pop;
    wb_state_e   state, nxt_state;
    logic [LANE_W-1:0] lane;
    logic        we_q, acc_q, accept, last_lane, frame_pend, ovf_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [W_PSUM-1:0]     wdata_q;

    // Stage p0..p(L-1): coordinate delay line aligned to pe_vld at the last tap
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            run_p0 <= 1'b0;
            for (int i = 0; i < PE_LATENCY; i++) beat_p[i] <= '0;
        end else begin
            run_p0    <= c_ctrl_data_run;
            beat_p[0] <= '{run: c_ctrl_data_run, row: c_row, col: c_col,
                           chn: c_chn_base, first: c_first_chn};
            for (int i = 1; i < PE_LATENCY; i++) beat_p[i] <= beat_p[i-1];
        end
    end

    assign o_req_ifm    = run_p0;
    assign o_req_filter = run_p0;

    always_comb begin
        pipe_busy = 1'b0;
        for (int i = 0; i < PE_LATENCY; i++) pipe_busy = pipe_busy | beat_p[i].run;
    end

    // Capture stage: result vector joins its coordinates in the FIFO
    assign entry_in = '{acc: pe_acc, row: beat_p[PE_LATENCY-1].row, col: beat_p[PE_LATENCY-1].col,
                        chn: beat_p[PE_LATENCY-1].chn, first: beat_p[PE_LATENCY-1].first};
    assign push     = pe_vld && !fifo_full;

    pe_wb_fifo #(.WIDTH($bits(entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .pop   (pop),
        .wdata (entry_in),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign accept    = we_q && psum.psum_ready;
    assign last_lane = (lane == LANE_W'(Tout - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= nxt_state;
    end

    // A drain starts only when the buffer can take data, so a stalled buffer keeps
    // entries queued; the next entry is chained straight in to avoid a lane bubble.
    always_comb begin
        nxt_state = state;
        pop       = 1'b0;
        case (state)
            S_IDLE:  if (!fifo_empty && psum.psum_ready) nxt_state = S_LOAD;
            S_LOAD: begin
                pop       = 1'b1;
                nxt_state = S_WRITE;
            end
            S_WRITE: begin
                if (accept && last_lane) begin
                    if (!fifo_empty) pop = 1'b1;
                    else             nxt_state = S_IDLE;
                end
            end
            default: nxt_state = S_IDLE;
        endcase
    end

    // Write stage: registered psum port, held while the buffer stalls
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hold    <= '0;
            lane    <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            acc_q   <= 1'b0;
        end else if (pop) begin
            hold    <= head;
            lane    <= '0;
            we_q    <= 1'b1;
            addr_q  <= lane_addr(head, '0);
            wdata_q <= lane_data(head, '0);
            acc_q   <= !head.first;
        end else if (accept) begin
            if (last_lane) begin
                we_q <= 1'b0;
            end else begin
                lane    <= lane + 1'b1;
                addr_q  <= lane_addr(hold, lane + 1'b1);
                wdata_q <= lane_data(hold, lane + 1'b1);
            end
        end
    end

    assign psum.psum_we    = we_q;
    assign psum.psum_addr  = addr_q;
    assign psum.psum_wdata = wdata_q;
    assign psum.psum_acc   = acc_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ovf_q      <= 1'b0;
            frame_pend <= 1'b0;
        end else begin
            if (pe_vld && fifo_full) ovf_q <= 1'b1;
            if (frame_pend && !o_busy) frame_pend <= 1'b0;
            else if (c_end_frame)      frame_pend <= 1'b1;
        end
    end

    assign o_busy       = pipe_busy || !fifo_empty || (state != S_IDLE);
    assign o_frame_done = frame_pend && !o_busy;
    assign o_err_ovf    = ovf_q;
endmodule
